// File: rtl/slt_seq_pkg.sv
// Shared types for the sequential set-on-compare unit.
package slt_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLT  = 2'b00,
    OP_SLTU = 2'b01,
    OP_SEQ  = 2'b10,
    OP_SLE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/slt_chunk_sub.sv
// One CHUNK-bit slice of the subtractor: a + ~b + cin, with slice-zero flag.
module slt_chunk_sub #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             zero_o
);

  // Ripple add of the inverted subtrahend; the carry-out feeds the next slice.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{CHUNK{1'b0}}, cin_i};
    zero_o          = (sum_o == '0);
  end

endmodule

// File: rtl/slt_seq_cmp.sv
// Multi-cycle set-on-compare engine: A - B one CHUNK slice per cycle, LSB first.
// Optional feature: define SLT_SEQ_CLEAR_EN to add a synchronous clr input.
module slt_seq_cmp
  import slt_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SLT_SEQ_CLEAR_EN
  input  logic             clr,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NSL = WIDTH / CHUNK;
  localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_e              op_q, op_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] s;
  logic             c, szero, last;
  logic             a_msb, b_msb, s_msb, ovf_w, slt_w, sltu_w, eq_w;
  logic             clr_w;

`ifdef SLT_SEQ_CLEAR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  slt_chunk_sub #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a_i   (a_q[CHUNK-1:0]),
    .b_i   (b_q[CHUNK-1:0]),
    .cin_i (carry_q),
    .sum_o (s),
    .cout_o(c),
    .zero_o(szero)
  );

  // Final-slice flag derivation; the live low chunk of the shifted operands
  // holds the original MSBs on the last slice.
  always_comb begin
    last   = (cnt_q == LAST);
    a_msb  = a_q[CHUNK-1];
    b_msb  = b_q[CHUNK-1];
    s_msb  = s[CHUNK-1];
    ovf_w  = (a_msb ^ b_msb) & (a_msb ^ s_msb);
    slt_w  = s_msb ^ ovf_w;
    sltu_w = ~c;
    eq_w   = zero_q & szero;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (clr_w) state_d = ST_IDLE;
  end

  // Datapath next values: capture, shift-and-accumulate, final flag latch.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op_e'(op);
          carry_d = 1'b1;
          zero_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = c;
        zero_d  = zero_q & szero;
        if (last) begin
          ovf_d = ovf_w;
          unique case (op_q)
            OP_SLT:  res_d = slt_w;
            OP_SLTU: res_d = sltu_w;
            OP_SEQ:  res_d = eq_w;
            OP_SLE:  res_d = slt_w | eq_w;
            default: res_d = 1'b0;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    if (clr_w) begin
      res_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_SLT;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and result outputs, all from registered state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    result    = '0;
    result[0] = res_q;
    overflow  = ovf_q;
  end

endmodule
